// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32/RV64 immediate generator with valid/ready and optional skid entry
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_type,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;
    localparam logic [2:0] T_ZIMM  = 3'd7;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        sgn;
    logic        is_shift;
    logic [63:0] dec_imm64;
    logic [2:0]  dec_type;
    logic [XLEN-1:0] dec_imm;

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign sgn      = in_instr[31];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Immediates are built 64 bits wide and truncated, so RV32 and RV64 share one decoder.
    always_comb begin
        dec_imm64 = 64'd0;
        dec_type  = T_NONE;
        case (opc)
            7'b0010011: begin
                if (is_shift) begin
                    dec_type  = T_SHAMT;
                    dec_imm64 = (XLEN == 64) ? {58'd0, in_instr[25:20]} : {59'd0, in_instr[24:20]};
                end else begin
                    dec_type  = T_I;
                    dec_imm64 = {{52{sgn}}, in_instr[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_type  = T_I;
                dec_imm64 = {{52{sgn}}, in_instr[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_type  = T_SHAMT;
                        dec_imm64 = {59'd0, in_instr[24:20]};
                    end else begin
                        dec_type  = T_I;
                        dec_imm64 = {{52{sgn}}, in_instr[31:20]};
                    end
                end
            end
            7'b0100011: begin
                dec_type  = T_S;
                dec_imm64 = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_type  = T_B;
                dec_imm64 = {{51{sgn}}, sgn, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type  = T_U;
                dec_imm64 = {{32{sgn}}, in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_type  = T_J;
                dec_imm64 = {{43{sgn}}, sgn, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                if (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) begin
                    dec_type  = T_ZIMM;
                    dec_imm64 = {59'd0, in_instr[19:15]};
                end
            end
            default: ;
        endcase
    end

    assign dec_imm = dec_imm64[XLEN-1:0];

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_type_q, out_type_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_type_q, skid_type_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_xfer;
    logic             out_free;

    // With the skid entry, in_ready depends only on registered state, never on out_ready.
    assign in_ready = !rst && ((SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready));
    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_type_d   = out_type_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_type_d   = skid_type_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = in_xfer;
                if (in_xfer) begin
                    skid_imm_d  = dec_imm;
                    skid_type_d = dec_type;
                    skid_tag_d  = in_tag;
                end
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) begin
                    out_imm_d  = dec_imm;
                    out_type_d = dec_type;
                    out_tag_d  = in_tag;
                end
            end
        end else if (in_xfer && SKID != 0) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_type_d  = dec_type;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_type_q   <= T_NONE;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= T_NONE;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_type_q   <= out_type_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_imm      = out_imm_q;
    assign out_imm_type = out_type_q;
    assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed vector bench for imm_gen_pipe at XLEN=32 and XLEN=64
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32, out_tag32;
    logic [2:0]  out_type32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_type64;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_imm_type(out_type32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID(1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_imm_type(out_type64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] e32;
        logic [2:0]  t32;
        logic [63:0] e64;
        logic [2:0]  t64;
    } vec_t;

    vec_t vecs[17];
    int   got[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1}; // addi -1
        vecs[1]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3}; // beq -8
        vecs[2]  = '{32'h43F0D093, 32'h0000001F, 3'd6, 64'h000000000000003F, 3'd6}; // srai
        vecs[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4}; // lui
        vecs[4]  = '{32'h305FD0F3, 32'h0000001F, 3'd7, 64'h000000000000001F, 3'd7}; // csrrwi
        vecs[5]  = '{32'h002081B3, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0}; // add
        vecs[6]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2}; // sw -4
        vecs[7]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5}; // jal -4
        vecs[8]  = '{32'h00001517, 32'h00001000, 3'd4, 64'h0000000000001000, 3'd4}; // auipc
        vecs[9]  = '{32'h00509093, 32'h00000005, 3'd6, 64'h0000000000000005, 3'd6}; // slli 5
        vecs[10] = '{32'h0010809B, 32'h00000000, 3'd0, 64'h0000000000000001, 3'd1}; // addiw
        vecs[11] = '{32'h0210909B, 32'h00000000, 3'd0, 64'h0000000000000001, 3'd6}; // slliw, bit25 set
        vecs[12] = '{32'hFFC12083, 32'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC, 3'd1}; // lw -4
        vecs[13] = '{32'h00000073, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0}; // ecall
        vecs[14] = '{32'h30529073, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0}; // csrrw
        vecs[15] = '{32'h02009093, 32'h00000000, 3'd6, 64'h0000000000000020, 3'd6}; // slli 32
        vecs[16] = '{32'h00112623, 32'h0000000C, 3'd2, 64'h000000000000000C, 3'd2}; // sw 12

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_tag = 32'h0;
        step();
        step();
        chk("rst_in_ready32", {63'd0, in_ready32}, 64'd0);
        chk("rst_in_ready64", {63'd0, in_ready64}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_out_imm", out_imm64, 64'd0);
        chk("rst_out_type", {61'd0, out_type32}, 64'd0);
        chk("rst_out_tag", {32'd0, out_tag32}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready32}, 64'd1);

        // Vector table: one instruction per two cycles, downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = 32'(i + 100);
            #1;
            chk($sformatf("v%0d_in_ready", i), {62'd0, in_ready32, in_ready64}, 64'd3);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), {62'd0, out_valid32, out_valid64}, 64'd3);
            chk($sformatf("v%0d_imm32", i), {32'd0, out_imm32}, {32'd0, vecs[i].e32});
            chk($sformatf("v%0d_type32", i), {61'd0, out_type32}, {61'd0, vecs[i].t32});
            chk($sformatf("v%0d_imm64", i), out_imm64, vecs[i].e64);
            chk($sformatf("v%0d_type64", i), {61'd0, out_type64}, {61'd0, vecs[i].t64});
            chk($sformatf("v%0d_tag", i), {out_tag32, out_tag64}, {32'(i + 100), 32'(i + 100)});
            step();
            chk($sformatf("v%0d_drained", i), {63'd0, out_valid32}, 64'd0);
        end

        // Skid fill with stalled output, then in-order drain.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd1;
        step();
        chk("skid_first_valid", {63'd0, out_valid32}, 64'd1);
        chk("skid_ready_after1", {63'd0, in_ready32}, 64'd1);
        in_instr = 32'hFE000CE3; in_tag = 32'd2;
        step();
        chk("skid_ready_after2", {63'd0, in_ready32}, 64'd0);
        in_instr = 32'h800000B7; in_tag = 32'd3;
        step();
        chk("skid_stall_ready", {63'd0, in_ready32}, 64'd0);
        chk("skid_stall_tag", {32'd0, out_tag32}, 64'd1);
        chk("skid_stall_imm", {32'd0, out_imm32}, 64'hFFFFFFFF);
        chk("skid_stall_type", {61'd0, out_type32}, 64'd1);
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            automatic logic xin  = in_valid && in_ready32;
            automatic logic xout = out_valid32 && out_ready;
            if (xout) got.push_back(int'(out_tag32));
            @(posedge clk);
            #1;
            if (xin) in_valid = 1'b0;
            #1;
        end
        chk("skid_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("skid_order%0d", k), 64'((k < got.size()) ? got[k] : -1), 64'(k + 1));

        // Flush with both entries full.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h00001517; in_tag = 32'd10;
        step();
        in_tag = 32'd11;
        step();
        chk("fl_full_ready", {63'd0, in_ready32}, 64'd0);
        in_tag = 32'd12; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
        chk("fl_ready_after", {63'd0, in_ready32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_nothing_emerges", {63'd0, out_valid32}, 64'd0);

        // Flush with an accepting input: the flush-cycle instruction is dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_tag = 32'd20;
        step();
        in_tag = 32'd21; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_out_valid", {63'd0, out_valid32}, 64'd0);
        step();
        chk("fl2_still_empty", {63'd0, out_valid32}, 64'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd13;
        step();
        in_valid = 1'b0;
        chk("fl_next_valid", {63'd0, out_valid32}, 64'd1);
        chk("fl_next_tag", {32'd0, out_tag32}, 64'd13);
        chk("fl_next_imm", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        step();
        chk("fl_next_drained", {63'd0, out_valid32}, 64'd0);

        // Reset mid-stream.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h800000B7; in_tag = 32'd30;
        step();
        chk("mr_pre_valid", {63'd0, out_valid64}, 64'd1);
        rst = 1'b1;
        step();
        chk("mr_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
        chk("mr_imm", out_imm64, 64'd0);
        chk("mr_type", {58'd0, out_type32, out_type64}, 64'd0);
        chk("mr_tag", {out_tag32, out_tag64}, 64'd0);
        chk("mr_in_ready", {62'd0, in_ready32, in_ready64}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_in_ready_after", {62'd0, in_ready32, in_ready64}, 64'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
